leaf_stream_buffer: RTL and testbench
=====================================

// Module: leaf_stream_buffer
// PURPOSE
//  - Leaf-level stream stage placed directly under the generated rootModule hierarchy nodes.
//  - Feeds data to the sibling inst_N leaves through a valid/ready interface.
//  - Decouples producer and consumer with a DEPTH-entry first-word-fall-through FIFO.
//  - Signals near-full back-pressure and reports occupancy.
// PARAMETERS
//  WIDTH      8   data word width in bits (>=1)
//  DEPTH      4   FIFO entries; power of two, >=2
//  AFULL_LVL  3   almost_full asserts when count >= AFULL_LVL (1..DEPTH)
// PORTS
//  clk          in   1                  single clock, rising edge
//  rst_n        in   1                  asynchronous active-low reset
//  in_valid     in   1                  producer word valid
//  in_ready     out  1                  buffer can accept; equals !full
//  in_data      in   WIDTH              producer word
//  out_valid    out  1                  head word valid; equals !empty
//  out_ready    in   1                  consumer accepts head word
//  out_data     out  WIDTH              head word, mem[rd_ptr]
//  almost_full  out  1                  count >= AFULL_LVL
//  count        out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst_n low, async assert, sync release): wr_ptr=rd_ptr=0, count=0.
//    in_ready=1, out_valid=0, almost_full=0.
//    out_data=0; memory contents are not reset.
//  - push = in_valid & in_ready; pop = out_valid & out_ready. Both act on the rising clk edge.
//  - Pointers are $clog2(DEPTH)+1 bits wide. The MSB is the wrap bit.
//    Both pointers increment modulo 2*DEPTH.
//    empty = (wr_ptr==rd_ptr); full = low bits equal and MSBs differ.
//  - Latency: a word pushed at edge N appears on out_data with out_valid=1 after edge N.
//    No combinational in->out bypass.
//  - count update: +1 on push only, -1 on pop only, unchanged on push&pop or on neither.
//  - Full state: in_ready=0, so in_valid is ignored. There is no write-through, even if out_ready=1.
//  - Empty state: out_valid=0, so out_ready is ignored. out_data holds the last value.
//  - Simultaneous push & pop when neither empty nor full: both pointers advance; count is held.
//  - A push into the slot just freed by a pop of a full FIFO happens no earlier than the next cycle.
//  - Producer rule: in_data must stay stable while in_valid=1 & in_ready=0.
//  - Consumer rule: out_valid never drops without a pop.
//  - Reset mid-operation: all stored words are discarded and outputs return to reset values at once.
//  - almost_full, in_ready, out_valid and count are decoded from registered state only (glitch-free).
// CONFIGURATION
//  LEAF_BUF_DROP_CNT_EN defined:
//   - Adds output drop_cnt [15:0].
//   - Increments on every cycle with in_valid=1 & in_ready=0. Saturates at 16'hFFFF.
//   - Reset value 0.
//   - Adds input drop_clr (1 bit); when high, synchronously clears drop_cnt.
//     Clear has priority over increment.
//  LEAF_BUF_DROP_CNT_EN undefined:
//   - Neither port exists; no counter logic is generated.
//   - All other behaviour is identical.
// TESTING
//  - Reset: set rst_n=0 mid-stream with count=2 -> the same cycle shows count=0, out_valid=0, in_ready=1.
//    After release, the first push of 8'h11 is visible on out_data 1 cycle later.
//  - Fill: push 8'hA0..A3 with out_ready=0 (DEPTH=4).
//    -> almost_full=1 after the 3rd push; in_ready=0 and count=4 after the 4th.
//    -> A 5th word 8'hFF is not stored.
//  - Drain: from full, hold out_ready=1 -> out_data A0,A1,A2,A3 on consecutive cycles, then out_valid=0 and count=0.
//  - Wrap/concurrent: stream 20 words 0..19 with in_valid=1 and out_ready toggling 1010...
//    -> output order is 0..19, no loss or duplication, count never exceeds 4.
//  - Full + pop + push same cycle: at count=4, set out_ready=1 and in_valid=1.
//    -> the head is popped, the new word is not accepted, count=3.
//    -> The word is accepted on the next cycle.
//  - With LEAF_BUF_DROP_CNT_EN: hold full with in_valid=1 for 5 cycles -> drop_cnt=5.
//    Then drop_clr=1 together with a drop -> drop_cnt=0.

Source files
------------

// File: rtl/leaf_stream_buffer.sv
// Leaf stream stage: DEPTH-entry first-word-fall-through FIFO with almost_full and occupancy.
// Optional macro LEAF_BUF_DROP_CNT_EN adds a saturating drop counter (drop_cnt / drop_clr).
module leaf_stream_buffer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count
`ifdef LEAF_BUF_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt,
    input  logic                     drop_clr
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty, full, push, pop;

    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign in_ready    = ~full;
    assign out_valid   = ~empty;
    assign count       = wr_ptr_q - rd_ptr_q;
    assign almost_full = (count >= PW'(AFULL_LVL));
    assign out_data    = out_data_q;

    always_comb begin
        push       = in_valid & ~full;
        pop        = out_ready & ~empty;
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        out_data_d = out_data_q;
        // Head register tracks mem[rd_ptr]; when the new head is the word being
        // written this edge, take it from in_data. An empty FIFO holds the last word.
        if (wr_ptr_d != rd_ptr_d) begin
            if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]))
                out_data_d = in_data;
            else
                out_data_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_data_q <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end

`ifdef LEAF_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_clr)
            drop_cnt_d = '0;
        else if (in_valid && full && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_leaf_stream_buffer.sv
// Directed bench for leaf_stream_buffer (WIDTH=8, DEPTH=4, AFULL_LVL=3): vector table plus corner sequences.
module tb_leaf_stream_buffer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       almost_full;
    logic [2:0] count;
`ifdef LEAF_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic        drop_clr = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    leaf_stream_buffer #(.WIDTH(8), .DEPTH(4), .AFULL_LVL(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .almost_full(almost_full), .count(count)
`ifdef LEAF_BUF_DROP_CNT_EN
        , .drop_cnt(drop_cnt), .drop_clr(drop_clr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_cnt;
        logic       e_ir;
        logic       e_af;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] id, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string name, input logic ov, input logic [7:0] od,
                             input logic [2:0] cnt, input logic ir, input logic af);
        chk({name, ".out_valid"},   {31'd0, out_valid},   {31'd0, ov});
        if (ov) chk({name, ".out_data"}, {24'd0, out_data}, {24'd0, od});
        chk({name, ".count"},       {29'd0, count},       {29'd0, cnt});
        chk({name, ".in_ready"},    {31'd0, in_ready},    {31'd0, ir});
        chk({name, ".almost_full"}, {31'd0, almost_full}, {31'd0, af});
    endtask

    initial begin
        int sent, recv, cyc;
        logic p_push, p_pop;

        //            iv  id     ordy ov  od     cnt  ir  af
        vecs[0]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 8'hA0, 3'd1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 8'hA0, 3'd2, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 8'hA0, 3'd3, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 8'hA0, 3'd4, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'hA0, 3'd4, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, 3'd3, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA2, 3'd2, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA3, 3'd1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA3, 3'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA3, 3'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h55, 3'd1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'h66, 1'b1, 1'b1, 8'h66, 3'd1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 3'd1, 1'b1, 1'b0};

        // Reset state
        #12;
        chk_state("reset", 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        chk("reset.out_data", {24'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill / overflow / drain / push-pop table
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].ordy);
            chk_state($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od,
                      vecs[i].e_cnt, vecs[i].e_ir, vecs[i].e_af);
        end
        chk("empty_hold.out_data", {24'd0, out_data}, 32'h66);

        // Asynchronous reset mid-stream with count=2
        drive(1'b1, 8'h77, 1'b0);
        chk("pre_rst.count", {29'd0, count}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk_state("mid_rst", 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        chk("mid_rst.out_data", {24'd0, out_data}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h11, 1'b0);
        chk_state("post_rst", 1'b1, 8'h11, 3'd1, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk_state("post_rst_drain", 1'b0, 8'h11, 3'd0, 1'b1, 1'b0);

        // Full + pop + push in the same cycle: push refused, accepted next cycle
        for (int i = 0; i < 4; i++) drive(1'b1, 8'hB0 + 8'(i), 1'b0);
        chk_state("full_b", 1'b1, 8'hB0, 3'd4, 1'b0, 1'b1);
        drive(1'b1, 8'hC0, 1'b1);
        chk_state("full_pop_push", 1'b1, 8'hB1, 3'd3, 1'b1, 1'b1);
        drive(1'b1, 8'hC0, 1'b0);
        chk_state("late_push", 1'b1, 8'hB1, 3'd4, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk("drain_b2", {24'd0, out_data}, 32'hB2);
        drive(1'b0, 8'h00, 1'b1);
        chk("drain_b3", {24'd0, out_data}, 32'hB3);
        drive(1'b0, 8'h00, 1'b1);
        chk("drain_c0", {24'd0, out_data}, 32'hC0);
        drive(1'b0, 8'h00, 1'b1);
        chk_state("drain_end", 1'b0, 8'hC0, 3'd0, 1'b1, 1'b0);

        // Wrap / concurrent stream: 20 words with out_ready toggling 1010...
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 20 && cyc < 200) begin
            @(negedge clk);
            in_valid  = (sent < 20);
            in_data   = 8'(sent);
            out_ready = ~cyc[0];
            #1;
            p_push = in_valid & in_ready;
            p_pop  = out_valid & out_ready;
            if (p_pop) begin
                chk($sformatf("stream.word%0d", recv), {24'd0, out_data}, recv);
                recv++;
            end
            if (p_push) sent++;
            @(posedge clk);
            #1;
            if (count > 3'd4) chk("stream.count_le4", {29'd0, count}, 32'd4);
            cyc++;
        end
        chk("stream.received", recv, 20);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk_state("stream_end", 1'b0, 8'd19, 3'd0, 1'b1, 1'b0);

`ifdef LEAF_BUF_DROP_CNT_EN
        chk("drop.initial", {16'd0, drop_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'hD0 + 8'(i), 1'b0);
        chk("drop.after_fill", {16'd0, drop_cnt}, 32'd0);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'hEE, 1'b0);
        chk("drop.five", {16'd0, drop_cnt}, 32'd5);
        @(negedge clk);
        drop_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("drop.clr_priority", {16'd0, drop_cnt}, 32'd0);
        @(negedge clk);
        drop_clr = 1'b0;
        @(posedge clk);
        #1;
        chk("drop.after_clr", {16'd0, drop_cnt}, 32'd1);
        in_valid = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
